qflatten_reg: RTL
=================

Name: qflatten_reg

Overview:
- Registered, generalised successor to the combinational queue flatten.
- Collapses FLAT_LVL+1 adjacent eot levels of a DIN_LVL-level queue into one level. The merge can start at any level START_LVL, not only at level 0.
- Optionally appends a running element index within the merged transaction.
- Output is fully registered through a 2-entry skid buffer, so it can sit on timing-critical dti paths between queue producers and consumers.

Parameters:
- TDIN, 16, payload data width in bits (>=1).
- DIN_LVL, 2, number of input eot levels (>=1).
- FLAT_LVL, 1, number of levels removed (1..DIN_LVL); DOUT_LVL = DIN_LVL-FLAT_LVL.
- START_LVL, 0, lowest merged level. Legal range when DOUT_LVL>0: START_LVL+FLAT_LVL <= DIN_LVL-1. Must be 0 when DOUT_LVL==0.
- IDX_W, 8, width of the appended element index; 0 = no index field.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- din  dti.consumer  TDIN+DIN_LVL  input queue; data layout {eot[DIN_LVL-1:0], data[TDIN-1:0]}.
- dout  dti.producer  TDIN+IDX_W+DOUT_LVL  output; data layout {eot[DOUT_LVL-1:0], idx[IDX_W-1:0], data[TDIN-1:0]}. Absent fields have zero width.

Behaviour:
- Eot mapping, DOUT_LVL>0:
  - merged = AND of din eot[START_LVL+FLAT_LVL:START_LVL].
  - out eot = {din eot[DIN_LVL-1:START_LVL+FLAT_LVL+1], merged, din eot[START_LVL-1:0]}; empty slices are omitted.
- Eot mapping, DOUT_LVL==0: all eot bits are dropped and merged is treated as 0.
- Data passes through unchanged.
- Index counter idx_cnt (IDX_W bits):
  - The accepted word carries the current idx_cnt.
  - On every din handshake: idx_cnt <= merged ? 0 : idx_cnt+1.
  - Wraps modulo 2^IDX_W.
  - With DOUT_LVL==0 it counts freely.
- Skid buffer: main register (drives dout) plus skid register.
  - dout.valid = main_valid.
  - din.ready = !skid_valid && !rst.
  - Handshake happens when valid&&ready on the same edge.
- Per cycle, given din handshake (in_hs) and dout handshake (out_hs):
  - main empty, in_hs: load main.
  - main full, out_hs, skid empty, in_hs: load main from din.
  - main full, !out_hs, in_hs: load skid.
  - out_hs with skid full: main <= skid, skid cleared. din.ready is 0 that cycle, so there is no in_hs.
  - out_hs, no in_hs, skid empty: main_valid <= 0.
- Latency: din accept to dout.valid is 1 cycle.
- Throughput: 1 word/cycle under continuous dout.ready.
- Ordering: strictly FIFO.
- dout.data is stable while dout.valid && !dout.ready.
- Reset values: main_valid=0, skid_valid=0, idx_cnt=0, dout.valid=0, din.ready=0 while rst is high and 1 after release. dout.data resets to 0.
- Reset mid-operation: buffered words are discarded and idx_cnt is cleared immediately (asynchronous). No partial transaction state survives reset.
- Generate-time checks: illegal parameter combinations (range rules above) trigger $error at elaboration.

Optional Feature:
- Macro: QFLATTEN_REG_IDX_SAT_EN.
- Defined: idx_cnt saturates at 2^IDX_W-1 and holds there until a merged eot resets it to 0. dout also gains 1-bit sideband port idx_ovf (output, registered alongside data), high on any word whose index saturated.
- Undefined: idx_cnt wraps; no idx_ovf port.
- The macro has no effect when IDX_W==0.

Test Plan:
1. DIN_LVL=2, FLAT_LVL=1, START_LVL=0, IDX_W=4; input eot sequence 00,01,00,11; dout.ready=1 -> out eot 0,0,0,1; idx 0,1,2,3; dout.valid 1 cycle after each din.valid.
2. DIN_LVL=3, FLAT_LVL=1, START_LVL=1; input eot=011 -> out eot=01; input eot=110 -> out eot=10; input eot=111 -> out eot=11.
3. Backpressure: stream 5 words with dout.ready=0 -> din.ready drops after 2 accepts. Raise ready -> words emerge in order, data unchanged, no loss or duplication.
4. Alternating dout.ready (1,0,1,0...) with continuous din.valid -> dout.data held stable while stalled; total order preserved; idx sequence continuous.
5. Reset asserted while both registers are full and idx_cnt=5 -> dout.valid=0 and din.ready=0 immediately. After release: din.ready=1 and the next word carries idx=0.
6. IDX_W=2, merged eot never set for 6 words -> idx 0,1,2,3,0,1 without macro. With QFLATTEN_REG_IDX_SAT_EN -> 0,1,2,3,3,3, with idx_ovf=1 on the last two words.

Source files
------------

// File: rtl/qflatten_reg.sv
// Registered queue flatten: merges FLAT_LVL+1 eot levels starting at START_LVL,
// appends a per-transaction element index, output via 2-entry skid buffer.
// Optional macro QFLATTEN_REG_IDX_SAT_EN: saturating index plus idx_ovf sideband.
module qflatten_reg #(
  parameter  int TDIN      = 16,
  parameter  int DIN_LVL   = 2,
  parameter  int FLAT_LVL  = 1,
  parameter  int START_LVL = 0,
  parameter  int IDX_W     = 8,
  localparam int DOUT_LVL  = DIN_LVL - FLAT_LVL,
  localparam int TDOUT     = TDIN + IDX_W + DOUT_LVL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TDIN+DIN_LVL-1:0] din_data,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [TDOUT-1:0]        dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready
`ifdef QFLATTEN_REG_IDX_SAT_EN
  ,
  output logic                    idx_ovf
`endif
);

  localparam int EW = (DOUT_LVL > 0) ? DOUT_LVL : 1;
`ifdef QFLATTEN_REG_IDX_SAT_EN
  localparam int OW = 1;
`else
  localparam int OW = 0;
`endif
  localparam int SW = TDOUT + OW;

  if (TDIN < 1 || DIN_LVL < 1 || IDX_W < 0) begin : g_chk_basic
    $error("qflatten_reg: TDIN and DIN_LVL must be >=1, IDX_W >=0");
  end
  if (FLAT_LVL < 1 || FLAT_LVL > DIN_LVL) begin : g_chk_flat
    $error("qflatten_reg: FLAT_LVL must be in 1..DIN_LVL");
  end
  if (DOUT_LVL > 0 && (START_LVL < 0 || START_LVL + FLAT_LVL > DIN_LVL - 1)) begin : g_chk_start
    $error("qflatten_reg: START_LVL+FLAT_LVL must be <= DIN_LVL-1");
  end
  if (DOUT_LVL == 0 && START_LVL != 0) begin : g_chk_start0
    $error("qflatten_reg: START_LVL must be 0 when all levels are flattened");
  end

  logic [DIN_LVL-1:0] eot_in;
  logic [EW-1:0]      eot_out;
  logic               merged;
  logic [SW-1:0]      word, main_q, skid_q;
  logic               main_valid, skid_valid;
  logic               in_hs, out_hs;

  assign eot_in = din_data[TDIN +: DIN_LVL];

  // Levels below START_LVL pass straight, the merged group collapses to one bit,
  // levels above it shift down by FLAT_LVL.
  if (DOUT_LVL > 0) begin : g_eot
    assign merged = &eot_in[START_LVL+FLAT_LVL:START_LVL];
    always_comb begin
      eot_out = '0;
      for (int i = 0; i < DOUT_LVL; i++) begin
        if (i < START_LVL)       eot_out[i] = eot_in[i];
        else if (i == START_LVL) eot_out[i] = merged;
        else                     eot_out[i] = eot_in[i+FLAT_LVL];
      end
    end
    assign word[TDIN+IDX_W +: DOUT_LVL] = eot_out[DOUT_LVL-1:0];
  end else begin : g_no_eot
    assign merged  = 1'b0;
    assign eot_out = '0;
  end

  assign word[TDIN-1:0] = din_data[TDIN-1:0];

  if (IDX_W > 0) begin : g_idx
    logic [IDX_W-1:0] idx_cnt;
    assign word[TDIN +: IDX_W] = idx_cnt;
`ifdef QFLATTEN_REG_IDX_SAT_EN
    // sat marks that the count has already tried to pass the maximum
    logic sat;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        idx_cnt <= '0;
        sat     <= 1'b0;
      end else if (in_hs) begin
        idx_cnt <= merged ? '0 : (&idx_cnt ? idx_cnt : idx_cnt + IDX_W'(1));
        sat     <= merged ? 1'b0 : (sat | (&idx_cnt));
      end
    end
    assign word[SW-1] = sat;
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        idx_cnt <= '0;
      else if (in_hs) idx_cnt <= merged ? '0 : idx_cnt + IDX_W'(1);
    end
`endif
  end else begin : g_no_idx
`ifdef QFLATTEN_REG_IDX_SAT_EN
    assign word[SW-1] = 1'b0;
`endif
  end

  assign din_ready  = !skid_valid && !rst;
  assign in_hs      = din_valid && din_ready;
  assign out_hs     = main_valid && dout_ready;
  assign dout_valid = main_valid;
  assign dout_data  = main_q[TDOUT-1:0];
`ifdef QFLATTEN_REG_IDX_SAT_EN
  assign idx_ovf    = main_q[SW-1];
`endif

  // Skid full implies din_ready low, so that branch never sees an input word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_hs) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || out_hs) begin
      main_valid <= in_hs;
      if (in_hs) main_q <= word;
    end else if (in_hs) begin
      skid_q     <= word;
      skid_valid <= 1'b1;
    end
  end

endmodule
